// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
//   Shared types and helpers for the N-key push-button conditioner.
//   - evt_t      : one queued key event {code, press, rpt}
//   - key_code_w : width of the key index field, max(1, clog2(n_keys))
//   - KEY_IDLE_N : raw level of a released key (active-low buttons)
// -----------------------------------------------------------------------------
package key_pkg;

   // Storage width of the code field; the top truncates it to its own KW,
   // so designs of up to 256 keys share this one event type.
   localparam int KEY_CODE_W = 8;

   // Raw key level when the button is not pressed.
   localparam logic KEY_IDLE_N = 1'b1;

   typedef struct packed {
      logic [KEY_CODE_W-1:0] code;
      logic                  press;
      logic                  rpt;
   } evt_t;

   function automatic int key_code_w(input int n_keys);
      if (n_keys <= 1) begin
         return 1;
      end else begin
         return $clog2(n_keys);
      end
   endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// -----------------------------------------------------------------------------
// key_debounce_chan
//   One key channel: 2-flop synchroniser, stable-count filter, debounced level
//   and one-cycle press/release pulses. With KEY_AUTOREPEAT_EN defined it also
//   runs a hold timer that emits repeat pulses while the key stays pressed.
//   Ports:
//     i_clk, i_rst   clock, asynchronous active-high reset
//     i_key_raw_n    raw asynchronous key, 0 = pressed
//     o_level        debounced state, 1 = pressed
//     o_press        1-cycle pulse when o_level rises
//     o_rel          1-cycle pulse when o_level falls
//     o_rpt          1-cycle auto-repeat pulse (0 without KEY_AUTOREPEAT_EN)
//   Build option: KEY_AUTOREPEAT_EN
// -----------------------------------------------------------------------------
module key_debounce_chan
   import key_pkg::*;
#(
   parameter int STABLE_CYC    = 1000000,
   parameter int CNT_W         = 20,
   parameter int REPEAT_DELAY  = 50000000,
   parameter int REPEAT_PERIOD = 10000000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_raw_n,
   output logic o_level,
   output logic o_press,
   output logic o_rel,
   output logic o_rpt
);

   logic [1:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_press;
   logic             r_rel;
   logic             w_key;
   logic             w_accept;

   // Two-flop synchroniser, reset to the released level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= {2{KEY_IDLE_N}};
      end else begin
         r_sync <= {r_sync[0], i_key_raw_n};
      end
   end

   // Synchronised key, 1 = pressed.
   assign w_key = ~r_sync[1];

   // The change is accepted on the STABLE_CYC-th consecutive differing cycle.
   assign w_accept = (w_key != r_level) && (r_cnt == CNT_W'(STABLE_CYC - 1));

   // Stable-count filter, debounced level and edge pulses.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_rel   <= 1'b0;
      end else begin
         r_press <= w_accept & w_key;
         r_rel   <= w_accept & ~w_key;
         if (w_accept) begin
            r_level <= w_key;
            r_cnt   <= '0;
         end else if (w_key == r_level) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;
   assign o_rel   = r_rel;

`ifdef KEY_AUTOREPEAT_EN
   localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);

   logic [HOLD_W-1:0] r_hold;
   logic              r_rpt;
   logic              w_hold_hit;

   // r_hold equals the number of cycles since the level rose; after a repeat it
   // is rewound by REPEAT_PERIOD so the next hit is exactly one period later.
   assign w_hold_hit = r_level && (r_hold == HOLD_W'(REPEAT_DELAY - 1));

   // Hold timer and repeat pulse; a repeat coinciding with the release is
   // suppressed so a channel never produces two events in one cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hold <= '0;
         r_rpt  <= 1'b0;
      end else begin
         r_rpt <= w_hold_hit & ~w_accept;
         if (!r_level) begin
            r_hold <= '0;
         end else if (w_hold_hit) begin
            r_hold <= HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);
         end else begin
            r_hold <= r_hold + HOLD_W'(1);
         end
      end
   end

   assign o_rpt = r_rpt;
`else
   assign o_rpt = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_n.sv
// -----------------------------------------------------------------------------
// key_debounce_n
//   N-channel push-button conditioner. Each key is synchronised and debounced
//   by a key_debounce_chan instance; the resulting press/release (and optional
//   auto-repeat) pulses are held in one pending slot per channel and presented
//   lowest-index first on a valid/ready event port. Dropped events set a
//   sticky overflow flag.
//   Ports:
//     sys_clk, sys_rst       clock, asynchronous active-high reset
//     key_raw_n  [N]         raw keys, 0 = pressed
//     key_level  [N]         debounced state, 1 = pressed
//     key_press / key_rel    1-cycle level rise / fall pulses
//     evt_valid / evt_ready  event handshake
//     evt_code [KW]          key index of the event
//     evt_press / evt_rpt    press (1) or release (0); auto-repeat press
//     evt_ovf / ovf_clr      sticky drop flag and its clear
//   Build option: KEY_AUTOREPEAT_EN enables per-key auto-repeat.
// -----------------------------------------------------------------------------
module key_debounce_n
   import key_pkg::*;
#(
   parameter int  N_KEYS        = 3,
   parameter int  STABLE_CYC    = 1000000,
   parameter int  CNT_W         = 20,
   parameter int  REPEAT_DELAY  = 50000000,
   parameter int  REPEAT_PERIOD = 10000000,
   localparam int KW            = key_code_w(N_KEYS)
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [N_KEYS-1:0] key_raw_n,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_rel,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [KW-1:0]     evt_code,
   output logic              evt_press,
   output logic              evt_rpt,
   output logic              evt_ovf,
   input  logic              ovf_clr
);

   logic [N_KEYS-1:0] w_press;
   logic [N_KEYS-1:0] w_rel;
   logic [N_KEYS-1:0] w_rpt;
   logic [N_KEYS-1:0] w_new;
   logic [N_KEYS-1:0] w_free;
   logic [N_KEYS-1:0] w_take;
   logic              w_load;
   logic              w_any;
   logic [KW-1:0]     w_sel;
   logic              w_sel_press;
   logic              w_sel_rpt;
   logic              w_drop;

   logic [N_KEYS-1:0] r_pend_v;
   logic [N_KEYS-1:0] r_pend_p;
   logic [N_KEYS-1:0] r_pend_r;
   evt_t              r_evt;
   logic              r_evt_valid;
   logic              r_ovf;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
      key_debounce_chan #(
         .STABLE_CYC   (STABLE_CYC),
         .CNT_W        (CNT_W),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_chan (
         .i_clk      (sys_clk),
         .i_rst      (sys_rst),
         .i_key_raw_n(key_raw_n[g]),
         .o_level    (key_level[g]),
         .o_press    (w_press[g]),
         .o_rel      (w_rel[g]),
         .o_rpt      (w_rpt[g])
      );
   end

   assign key_press = w_press;
   assign key_rel   = w_rel;

   // The output register may take a new event when empty or being accepted.
   assign w_load = ~r_evt_valid | evt_ready;

   // Lowest-index pending slot wins (descending scan, last hit kept) and is consumed on load.
   always_comb begin
      w_any       = 1'b0;
      w_sel       = '0;
      w_sel_press = 1'b0;
      w_sel_rpt   = 1'b0;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (r_pend_v[i]) begin
            w_any       = 1'b1;
            w_sel       = KW'(i);
            w_sel_press = r_pend_p[i];
            w_sel_rpt   = r_pend_r[i];
         end else begin
            w_any = w_any;
         end
      end
      for (int i = 0; i < N_KEYS; i++) begin
         w_take[i] = w_load & w_any & (w_sel == KW'(i));
      end
   end

   // A slot being consumed this cycle counts as free, so refill never drops.
   always_comb begin
      w_drop = 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
         w_new[i]  = w_press[i] | w_rel[i] | w_rpt[i];
         w_free[i] = ~r_pend_v[i] | w_take[i];
         w_drop    = w_drop | (w_new[i] & ~w_free[i]);
      end
   end

   // Per-channel pending slots: load on a new event, clear when consumed.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_pend_v <= '0;
         r_pend_p <= '0;
         r_pend_r <= '0;
      end else begin
         for (int i = 0; i < N_KEYS; i++) begin
            if (w_new[i] && w_free[i]) begin
               r_pend_v[i] <= 1'b1;
               r_pend_p[i] <= w_press[i] | w_rpt[i];
               r_pend_r[i] <= w_rpt[i];
            end else if (w_take[i]) begin
               r_pend_v[i] <= 1'b0;
            end else begin
               r_pend_v[i] <= r_pend_v[i];
            end
         end
      end
   end

   // Event output register; fields hold while valid and not accepted.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_evt_valid <= 1'b0;
         r_evt       <= '0;
      end else if (w_load) begin
         if (w_any) begin
            r_evt_valid <= 1'b1;
            r_evt.code  <= KEY_CODE_W'(w_sel);
            r_evt.press <= w_sel_press;
            r_evt.rpt   <= w_sel_rpt;
         end else begin
            r_evt_valid <= 1'b0;
         end
      end else begin
         r_evt_valid <= r_evt_valid;
      end
   end

   // Sticky overflow flag; a drop in the clearing cycle keeps it set.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= r_ovf;
      end
   end

   assign evt_valid = r_evt_valid;
   assign evt_code  = KW'(r_evt.code);
   assign evt_press = r_evt.press;
   assign evt_rpt   = r_evt.rpt;
   assign evt_ovf   = r_ovf;

endmodule
